// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S / left-justified audio transceiver.
package audio_pkg;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/audio_fifo.sv
// Single-clock FIFO with show-ahead read data; the extra pointer bit separates full from empty.
module audio_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_en,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/audio_i2s_xcvr.sv
// Codec-slave I2S / left-justified transceiver: per-channel playback and capture FIFOs,
// serial pins oversampled in the clk domain.
module audio_i2s_xcvr
  import audio_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] to_dac_left_channel_data,
  input  logic              to_dac_left_channel_valid,
  output logic              to_dac_left_channel_ready,
  input  logic [DATA_W-1:0] to_dac_right_channel_data,
  input  logic              to_dac_right_channel_valid,
  output logic              to_dac_right_channel_ready,
  output logic [DATA_W-1:0] from_adc_left_channel_data,
  output logic              from_adc_left_channel_valid,
  input  logic              from_adc_left_channel_ready,
  output logic [DATA_W-1:0] from_adc_right_channel_data,
  output logic              from_adc_right_channel_valid,
  input  logic              from_adc_right_channel_ready,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic              AUD_DACDAT,
  input  logic              lj_mode,
  input  logic              status_clear,
  output logic              dac_underflow,
  output logic              adc_overflow
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] bclk_sync, dlr_sync, alr_sync, adat_sync;
  logic [SYNC_STAGES:0]   primed;
  logic                   bclk_d, dlr_d, alr_d;
  logic                   bclk_s, dlr_s, alr_s, adat_s;
  logic                   armed, bclk_rise, bclk_fall;

  logic [DATA_W-1:0] dac_wr_data [2];
  logic [DATA_W-1:0] dac_rd_data [2];
  logic [DATA_W-1:0] adc_rd_data [2];
  logic [1:0]        dac_wr_en, dac_full, dac_empty, dac_pop;
  logic [1:0]        adc_push, adc_full, adc_empty, adc_rd_en;

  logic              dac_edge, adc_edge;
  slot_e             dac_sel, adc_sel;
  mode_e             dac_mode_q, adc_mode_q, dac_mode, adc_mode;
  logic [DATA_W-1:0] dac_word;

  logic [DATA_W-1:0] tx_shift;
  logic [CW-1:0]     tx_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [CW-1:0]     rx_cnt;
  logic              rx_skip;
  slot_e             rx_slot;
  logic              rx_done;
  logic [DATA_W-1:0] rx_word;
  slot_e             rx_word_slot;

  // Edges are only trusted once every stage holds a real pin sample, so a pin that is
  // already high at reset release does not look like a fresh LRCK edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      dlr_sync  <= '0;
      alr_sync  <= '0;
      adat_sync <= '0;
      primed    <= '0;
      bclk_d    <= 1'b0;
      dlr_d     <= 1'b0;
      alr_d     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      dlr_sync  <= {dlr_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      alr_sync  <= {alr_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      adat_sync <= {adat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
      bclk_d    <= bclk_s;
      dlr_d     <= dlr_s;
      alr_d     <= alr_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign dlr_s     = dlr_sync[SYNC_STAGES-1];
  assign alr_s     = alr_sync[SYNC_STAGES-1];
  assign adat_s    = adat_sync[SYNC_STAGES-1];
  assign armed     = primed[SYNC_STAGES];
  assign bclk_rise = armed && bclk_s && !bclk_d;
  assign bclk_fall = armed && !bclk_s && bclk_d;

  assign dac_edge = armed && (dlr_s != dlr_d);
  assign adc_edge = armed && (alr_s != alr_d);
  assign dac_sel  = dlr_s ? SLOT_RIGHT : SLOT_LEFT;
  assign adc_sel  = alr_s ? SLOT_RIGHT : SLOT_LEFT;
  assign dac_mode = (dac_edge && !dlr_s) ? mode_e'(lj_mode) : dac_mode_q;
  assign adc_mode = (adc_edge && !alr_s) ? mode_e'(lj_mode) : adc_mode_q;
  assign dac_word = dac_empty[dac_sel] ? '0 : dac_rd_data[dac_sel];

  assign dac_wr_data[0] = to_dac_left_channel_data;
  assign dac_wr_data[1] = to_dac_right_channel_data;
  assign dac_wr_en      = {to_dac_right_channel_valid, to_dac_left_channel_valid};
  assign adc_rd_en      = {from_adc_right_channel_ready, from_adc_left_channel_ready};

  assign to_dac_left_channel_ready    = reset && !dac_full[0];
  assign to_dac_right_channel_ready   = reset && !dac_full[1];
  assign from_adc_left_channel_valid  = !adc_empty[0];
  assign from_adc_right_channel_valid = !adc_empty[1];
  assign from_adc_left_channel_data   = adc_rd_data[0];
  assign from_adc_right_channel_data  = adc_rd_data[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    assign dac_pop[ch]  = dac_edge && (dac_sel == (ch == 0 ? SLOT_LEFT : SLOT_RIGHT)) && !dac_empty[ch];
    assign adc_push[ch] = rx_done && (rx_word_slot == (ch == 0 ? SLOT_LEFT : SLOT_RIGHT));

    audio_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_dac_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .wr_data (dac_wr_data[ch]),
      .wr_en   (dac_wr_en[ch]),
      .full    (dac_full[ch]),
      .rd_data (dac_rd_data[ch]),
      .rd_en   (dac_pop[ch]),
      .empty   (dac_empty[ch])
    );

    audio_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_adc_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .wr_data (rx_word),
      .wr_en   (adc_push[ch]),
      .full    (adc_full[ch]),
      .rd_data (adc_rd_data[ch]),
      .rd_en   (adc_rd_en[ch]),
      .empty   (adc_empty[ch])
    );
  end

  // A BCLK fall seen in the same cycle as the LRCK edge belongs to the old slot; in I2S
  // the MSB therefore goes out on the following fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift   <= '0;
      tx_cnt     <= '0;
      AUD_DACDAT <= 1'b0;
      dac_mode_q <= MODE_I2S;
    end else if (dac_edge) begin
      dac_mode_q <= dac_mode;
      if (dac_mode == MODE_LJ) begin
        AUD_DACDAT <= dac_word[DATA_W-1];
        tx_shift   <= {dac_word[DATA_W-2:0], 1'b0};
        tx_cnt     <= CW'(DATA_W - 1);
      end else begin
        tx_shift   <= dac_word;
        tx_cnt     <= CW'(DATA_W);
      end
    end else if (bclk_fall) begin
      if (tx_cnt != '0) begin
        AUD_DACDAT <= tx_shift[DATA_W-1];
        tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
        tx_cnt     <= tx_cnt - CW'(1);
      end else begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

  // Restarting on every LRCK edge silently drops a short frame's partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift     <= '0;
      rx_cnt       <= '0;
      rx_skip      <= 1'b0;
      rx_slot      <= SLOT_LEFT;
      rx_done      <= 1'b0;
      rx_word      <= '0;
      rx_word_slot <= SLOT_LEFT;
      adc_mode_q   <= MODE_I2S;
    end else begin
      rx_done <= 1'b0;
      if (adc_edge) begin
        adc_mode_q <= adc_mode;
        rx_slot    <= adc_sel;
        rx_skip    <= (adc_mode == MODE_I2S);
        rx_cnt     <= CW'(DATA_W);
        rx_shift   <= '0;
      end else if (bclk_rise) begin
        if (rx_skip) begin
          rx_skip <= 1'b0;
        end else if (rx_cnt != '0) begin
          rx_shift <= {rx_shift[DATA_W-3:0], adat_s};
          rx_cnt   <= rx_cnt - CW'(1);
          if (rx_cnt == CW'(1)) begin
            rx_done      <= 1'b1;
            rx_word      <= {rx_shift, adat_s};
            rx_word_slot <= rx_slot;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac_underflow <= 1'b0;
      adc_overflow  <= 1'b0;
    end else begin
      if (dac_edge && dac_empty[dac_sel]) dac_underflow <= 1'b1;
      else if (status_clear)              dac_underflow <= 1'b0;
      if (rx_done && adc_full[rx_word_slot]) adc_overflow <= 1'b1;
      else if (status_clear)                 adc_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_xcvr.sv
// Directed bench: codec model (BCLK/LRCK generator, I2S ADC source, DAC serial monitor) around audio_i2s_xcvr.
module tb_audio_i2s_xcvr;

  localparam int DW = 24;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] dl_data = '0, dr_data = '0;
  logic          dl_valid = 1'b0, dr_valid = 1'b0;
  logic          dl_ready, dr_ready;
  logic [DW-1:0] al_data, ar_data;
  logic          al_valid, ar_valid;
  logic          al_ready = 1'b1, ar_ready = 1'b1;
  logic          aud_bclk = 1'b1;
  logic          lrck = 1'b1;
  logic          adcdat, dacdat;
  logic          tb_adcdat = 1'b0;
  logic          loop_en = 1'b0;
  logic          lj_mode = 1'b0;
  logic          status_clear = 1'b0;
  logic          dac_underflow, adc_overflow;

  int            n_vec = 0;
  int            n_miss = 0;

  int            bc = 63;
  int            gen_pos;
  logic [DW-1:0] gen_src;
  logic [DW-1:0] adc_src [2];
  int            mpos;
  int            mslot;
  logic          tb_lj = 1'b0;
  logic          mon_lj = 1'b0;
  logic [DW-1:0] mon_acc = '0;
  logic          mon_tail = 1'b0;
  logic [DW-1:0] dac_got [2];
  logic          dac_tail [2];
  logic [DW-1:0] q_l [$];
  logic [DW-1:0] q_r [$];

  assign adcdat = loop_en ? dacdat : tb_adcdat;

  audio_i2s_xcvr #(.DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .to_dac_left_channel_data     (dl_data),
    .to_dac_left_channel_valid    (dl_valid),
    .to_dac_left_channel_ready    (dl_ready),
    .to_dac_right_channel_data    (dr_data),
    .to_dac_right_channel_valid   (dr_valid),
    .to_dac_right_channel_ready   (dr_ready),
    .from_adc_left_channel_data   (al_data),
    .from_adc_left_channel_valid  (al_valid),
    .from_adc_left_channel_ready  (al_ready),
    .from_adc_right_channel_data  (ar_data),
    .from_adc_right_channel_valid (ar_valid),
    .from_adc_right_channel_ready (ar_ready),
    .AUD_BCLK                     (aud_bclk),
    .AUD_DACLRCK                  (lrck),
    .AUD_ADCLRCK                  (lrck),
    .AUD_ADCDAT                   (adcdat),
    .AUD_DACDAT                   (dacdat),
    .lj_mode                      (lj_mode),
    .status_clear                 (status_clear),
    .dac_underflow                (dac_underflow),
    .adc_overflow                 (adc_overflow)
  );

  always #5 clk = ~clk;
  always #40 aud_bclk = ~aud_bclk;

  // Codec: 64 BCLK per frame, LRCK and ADC data change on BCLK falls, ADC source is I2S formatted.
  always @(negedge aud_bclk) begin
    bc      = (bc + 1) % 64;
    lrck    = (bc >= 32);
    gen_pos = bc % 32;
    gen_src = lrck ? adc_src[1] : adc_src[0];
    tb_adcdat = (gen_pos >= 1 && gen_pos <= 24) ? gen_src[24 - gen_pos] : 1'b0;
  end

  // DAC receiver model: collects the slot word per the mode in force at the frame start.
  always @(posedge aud_bclk) begin
    mpos  = bc % 32;
    mslot = (bc >= 32) ? 1 : 0;
    if (mpos == 0) begin
      mon_acc  = '0;
      mon_tail = 1'b0;
      if (mslot == 0) mon_lj = tb_lj;
    end
    if (mon_lj ? (mpos < 24) : (mpos >= 1 && mpos <= 24)) mon_acc = {mon_acc[DW-2:0], dacdat};
    else if (mpos != 0) mon_tail = mon_tail | dacdat;
    if (mpos == 31) begin
      dac_got[mslot]  = mon_acc;
      dac_tail[mslot] = mon_tail;
    end
  end

  always @(negedge clk) begin
    if (al_valid && al_ready) q_l.push_back(al_data);
    if (ar_valid && ar_ready) q_r.push_back(ar_data);
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_pos(input int p);
    for (int i = 0; i < 64 && (bc % 32) != p; i++) begin
      @(negedge aud_bclk);
      #1;
    end
  endtask

  task automatic sync_mid_right();
    @(posedge lrck);
    wait_pos(4);
  endtask

  task automatic push_dac(input bit side, input logic [DW-1:0] w);
    int n = 0;
    @(negedge clk);
    if (side) begin dr_data = w; dr_valid = 1'b1; end
    else      begin dl_data = w; dl_valid = 1'b1; end
    while (((side ? dr_ready : dl_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 50) begin
      n_miss++;
      $display("FAIL push_timeout side=%0d got ready=0 want ready=1", side);
    end
    @(negedge clk);
    dl_valid = 1'b0;
    dr_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    status_clear = 1'b1;
    @(negedge clk);
    status_clear = 1'b0;
  endtask

  task automatic test_reset();
    #22;
    n_vec++; if (dacdat !== 1'b0) begin n_miss++; $display("FAIL rst_dacdat got %b want 0", dacdat); end
    n_vec++; if ({dl_ready, dr_ready} !== 2'b00) begin n_miss++; $display("FAIL rst_ready got %b want 00", {dl_ready, dr_ready}); end
    n_vec++; if ({al_valid, ar_valid} !== 2'b00) begin n_miss++; $display("FAIL rst_valid got %b want 00", {al_valid, ar_valid}); end
    n_vec++; if ({dac_underflow, adc_overflow} !== 2'b00) begin n_miss++; $display("FAIL rst_flags got %b want 00", {dac_underflow, adc_overflow}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({dl_ready, dr_ready} !== 2'b11) begin n_miss++; $display("FAIL rel_ready got %b want 11", {dl_ready, dr_ready}); end
  endtask

  task automatic test_dac_i2s();
    sync_mid_right();
    push_dac(1'b0, 24'hA5A5A5);
    push_dac(1'b1, 24'h5A5A5A);
    @(negedge lrck);
    @(posedge lrck);
    #1;
    n_vec++; if (dac_got[0] !== 24'hA5A5A5) begin n_miss++; $display("FAIL i2s_dac_left got %h want a5a5a5", dac_got[0]); end
    n_vec++; if (dac_tail[0] !== 1'b0) begin n_miss++; $display("FAIL i2s_dac_left_pad got %b want 0", dac_tail[0]); end
    @(negedge lrck);
    #1;
    n_vec++; if (dac_got[1] !== 24'h5A5A5A) begin n_miss++; $display("FAIL i2s_dac_right got %h want 5a5a5a", dac_got[1]); end
    n_vec++; if (dac_tail[1] !== 1'b0) begin n_miss++; $display("FAIL i2s_dac_right_pad got %b want 0", dac_tail[1]); end
  endtask

  task automatic test_underflow();
    sync_mid_right();
    wait_pos(28);
    pulse_clear();
    n_vec++; if (dac_underflow !== 1'b0) begin n_miss++; $display("FAIL uf_cleared got %b want 0", dac_underflow); end
    @(negedge lrck);
    @(posedge lrck);
    #1;
    n_vec++; if (dac_got[0] !== 24'h000000 || dac_tail[0] !== 1'b0) begin n_miss++; $display("FAIL uf_zero_slot got %h/%b want 000000/0", dac_got[0], dac_tail[0]); end
    n_vec++; if (dac_underflow !== 1'b1) begin n_miss++; $display("FAIL uf_set got %b want 1", dac_underflow); end
    pulse_clear();
    n_vec++; if (dac_underflow !== 1'b0) begin n_miss++; $display("FAIL uf_clear got %b want 0", dac_underflow); end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    sync_mid_right();
    push_dac(1'b0, 24'h123456);
    push_dac(1'b1, 24'hFEDCBA);
    wait_pos(28);
    q_l.delete();
    q_r.delete();
    @(negedge lrck);
    @(posedge lrck);
    @(negedge lrck);
    repeat (40) @(negedge clk);
    n_vec++; if (q_l.size() != 1) begin n_miss++; $display("FAIL loop_left_count got %0d want 1", q_l.size()); end
    else begin
      n_vec++; if (q_l[0] !== 24'h123456) begin n_miss++; $display("FAIL loop_left got %h want 123456", q_l[0]); end
    end
    n_vec++; if (q_r.size() != 1) begin n_miss++; $display("FAIL loop_right_count got %0d want 1", q_r.size()); end
    else begin
      n_vec++; if (q_r[0] !== 24'hFEDCBA) begin n_miss++; $display("FAIL loop_right got %h want fedcba", q_r[0]); end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_overflow();
    sync_mid_right();
    wait_pos(28);
    pulse_clear();
    @(posedge clk); #1 al_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      adc_src[0] = DW'(k);
      @(negedge lrck);
      @(posedge lrck);
      if (k == 8) begin
        n_vec++; if (adc_overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_at_full got %b want 0", adc_overflow); end
      end
    end
    adc_src[0] = '0;
    n_vec++; if (adc_overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_set got %b want 1", adc_overflow); end
    n_vec++; if (al_valid !== 1'b1) begin n_miss++; $display("FAIL ovf_valid got %b want 1", al_valid); end
    q_l.delete();
    @(posedge clk); #1 al_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (q_l.size() != FD) begin n_miss++; $display("FAIL ovf_count got %0d want %0d", q_l.size(), FD); end
    for (int i = 0; i < FD && i < q_l.size(); i++) begin
      n_vec++; if (q_l[i] !== DW'(i + 1)) begin n_miss++; $display("FAIL ovf_word%0d got %h want %h", i, q_l[i], DW'(i + 1)); end
    end
  endtask

  task automatic test_lj();
    sync_mid_right();
    lj_mode = 1'b1;
    tb_lj = 1'b1;
    adc_src[0] = 24'h8F0F0F;
    adc_src[1] = 24'h2468AC;
    push_dac(1'b0, 24'hC00003);
    push_dac(1'b1, 24'h7FFFFE);
    wait_pos(28);
    q_l.delete();
    q_r.delete();
    @(negedge lrck);
    @(posedge lrck);
    #1;
    n_vec++; if (dac_got[0] !== 24'hC00003 || dac_tail[0] !== 1'b0) begin n_miss++; $display("FAIL lj_dac_left got %h/%b want c00003/0", dac_got[0], dac_tail[0]); end
    @(negedge lrck);
    #1;
    n_vec++; if (dac_got[1] !== 24'h7FFFFE || dac_tail[1] !== 1'b0) begin n_miss++; $display("FAIL lj_dac_right got %h/%b want 7ffffe/0", dac_got[1], dac_tail[1]); end
    repeat (40) @(negedge clk);
    n_vec++; if (q_l.size() < 1 || q_l[0] !== 24'h478787) begin n_miss++; $display("FAIL lj_adc_left got n=%0d w=%h want 478787", q_l.size(), (q_l.size() > 0) ? q_l[0] : 24'h0); end
    n_vec++; if (q_r.size() < 1 || q_r[0] !== 24'h123456) begin n_miss++; $display("FAIL lj_adc_right got n=%0d w=%h want 123456", q_r.size(), (q_r.size() > 0) ? q_r[0] : 24'h0); end
    sync_mid_right();
    lj_mode = 1'b0;
    tb_lj = 1'b0;
    adc_src[0] = '0;
    adc_src[1] = '0;
    @(negedge lrck);
  endtask

  task automatic test_reset_mid();
    logic stray;
    sync_mid_right();
    push_dac(1'b0, 24'hFFFFFF);
    push_dac(1'b1, 24'hFFFFFF);
    @(negedge lrck);
    wait_pos(10);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (dacdat !== 1'b0) begin n_miss++; $display("FAIL rmid_dacdat got %b want 0", dacdat); end
    n_vec++; if ({dac_underflow, adc_overflow} !== 2'b00) begin n_miss++; $display("FAIL rmid_flags got %b want 00", {dac_underflow, adc_overflow}); end
    n_vec++; if ({dl_ready, dr_ready, al_valid, ar_valid} !== 4'b0000) begin n_miss++; $display("FAIL rmid_hs got %b want 0000", {dl_ready, dr_ready, al_valid, ar_valid}); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({dl_ready, dr_ready} !== 2'b11) begin n_miss++; $display("FAIL rmid_rel_ready got %b want 11", {dl_ready, dr_ready}); end
    stray = 1'b0;
    for (int i = 0; i < 40 && !lrck; i++) begin
      @(posedge aud_bclk);
      #1;
      stray = stray | dacdat;
    end
    n_vec++; if (stray !== 1'b0) begin n_miss++; $display("FAIL rmid_idle_slot got %b want 0", stray); end
    @(negedge lrck);
    #1;
    n_vec++; if (dac_got[1] !== 24'h000000) begin n_miss++; $display("FAIL rmid_flushed got %h want 000000", dac_got[1]); end
    n_vec++; if (dac_underflow !== 1'b1) begin n_miss++; $display("FAIL rmid_uf got %b want 1", dac_underflow); end
  endtask

  initial begin
    adc_src[0] = '0;
    adc_src[1] = '0;
    dac_got[0] = '0;
    dac_got[1] = '0;
    dac_tail[0] = 1'b0;
    dac_tail[1] = 1'b0;
    test_reset();
    test_dac_i2s();
    test_underflow();
    test_loopback();
    test_overflow();
    test_lj();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/audio_i2s_xcvr.md
AUDIO_I2S_XCVR -- requirements
Module: audio_i2s_xcvr

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning sample width in bits (16..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning words per channel FIFO (power of two, >=2).
REQ-003 SHALL have ports: clk  in  1  system clock, >=4x AUD_BCLK; one clock domain only.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: to_dac_{left,right}_channel_data  in  DATA_W  playback sample; to_dac_*_valid  in  1; to_dac_*_ready  out  1.
REQ-006 SHALL have ports: from_adc_{left,right}_channel_data  out  DATA_W  capture sample; from_adc_*_valid  out  1; from_adc_*_ready  in  1.
REQ-007 SHALL have ports: AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_ADCDAT  in  1  codec-mastered serial pins, asynchronous to clk.
REQ-008 SHALL have ports: AUD_DACDAT  out  1  serial playback data.
REQ-009 SHALL have ports: lj_mode  in  1  0 = I2S (one-bit delay), 1 = left-justified.
REQ-010 SHALL have ports: status_clear  in  1; dac_underflow  out  1; adc_overflow  out  1  sticky flags.

Function
REQ-011 SHALL synchronise AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_ADCDAT through two flops and detect edges on the synchronised copies.
REQ-012 SHALL treat LRCK low as left slot, LRCK high as right slot.
REQ-013 SHALL latch lj_mode at each synchronised LRCK falling edge; mid-frame changes take effect next frame.
REQ-014 SHALL buffer each of the four streams in its own FIFO of FIFO_DEPTH words; ready = not full, valid = not empty; transfer when valid and ready on a clk rising edge.
REQ-015 SHALL, on each DACLRCK edge, pop one word from the slot's DAC FIFO into the transmit shifter; if empty, load zero and set dac_underflow.
REQ-016 SHALL change AUD_DACDAT only on synchronised BCLK falling edges, MSB first; MSB driven on first falling edge after the LRCK edge (I2S) or immediately on LRCK edge detection (LJ).
REQ-017 SHALL drive AUD_DACDAT 0 after the DATA_W-th bit until the next LRCK edge.
REQ-018 SHALL sample AUD_ADCDAT on synchronised BCLK rising edges; skip the first rising edge in I2S mode; capture DATA_W bits MSB first, ignore extra bits.
REQ-019 SHALL push the captured word into the slot's ADC FIFO one clk after the DATA_W-th bit; if full, discard the new word and set adc_overflow.
REQ-020 SHALL discard a partial word when an LRCK edge arrives before DATA_W bits (short frame); no push, no flag.
REQ-021 SHALL hold sticky flags until status_clear=1; a set event and clear in the same cycle leave the flag set.
REQ-022 SHALL allow simultaneous push and pop on a full or empty FIFO without loss (pop on empty or push on full is blocked per REQ-014).
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with an extra bit for full/empty distinction.

Reset
REQ-024 SHALL, while reset=0, empty all FIFOs, clear shifters and bit counters, and hold AUD_DACDAT=0, all *_valid=0, all *_ready=0, both flags=0.
REQ-025 SHALL drive *_ready=1 the first cycle after reset release.
REQ-026 SHALL keep transmitter and receiver idle after reset release until the first synchronised LRCK edge; no partial slot is played or captured.

Structure
REQ-027 SHALL place slot enum (LEFT, RIGHT), mode encodings and synchroniser depth constant in the shared package audio_pkg.
REQ-028 SHALL instantiate sub-module audio_fifo (parameterised width/depth, sync, async active-low reset) four times.

Verification
REQ-029 SHALL cover: DATA_W=24, I2S, BCLK=64fs, push L=0xA5A5A5, R=0x5A5A5A -> DACDAT serialises 1010_0101... from second BCLK rise after DACLRCK fall, then R word after rise.
REQ-030 SHALL cover: loopback AUD_DACDAT->AUD_ADCDAT, push L=0x123456, R=0xFEDCBA -> from_adc left 0x123456, right 0xFEDCBA, in order.
REQ-031 SHALL cover: no DAC data at frame start -> DACDAT all zero for slot, dac_underflow=1 until status_clear pulse, then 0.
REQ-032 SHALL cover: from_adc_left_ready=0 for FIFO_DEPTH+1 left words 1..9 -> adc_overflow=1, reads return 1..8, word 9 lost.
REQ-033 SHALL cover: lj_mode=1 -> MSB appears before first BCLK rise of slot; captured word equals I2S result shifted by one bit position.
REQ-034 SHALL cover: reset asserted mid-slot -> DACDAT=0, FIFOs empty, flags 0; after release first output begins at next LRCK edge.
